// File: rtl/led_pkg.sv
// led_pkg: shared constants and the saturating level-step helper for the LED
// fade/PWM output stage.
//   DEF_NUM_LEDS / DEF_PWM_BITS / DEF_STEP_FRAMES : default parameter values
//   MAX_LEVEL                                    : full-on level at default resolution
//   sat_step(level, step, max_level, up)          : level +/- step, clamped to [0, max_level]
package led_pkg;

    localparam int DEF_NUM_LEDS    = 8;
    localparam int DEF_PWM_BITS    = 4;
    localparam int DEF_STEP_FRAMES = 4;
    localparam int MAX_LEVEL       = 2**DEF_PWM_BITS - 1;

    // Working width of sat_step; callers zero-extend into it and truncate the
    // result back, so any PWM_BITS up to SAT_W is supported.
    localparam int SAT_W = 16;

    // One extra bit catches both overflow past max_level and underflow below 0.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] level,
        input logic [SAT_W-1:0] step,
        input logic [SAT_W-1:0] max_level,
        input logic             up
    );
        logic [SAT_W:0] sum;
        if (up) begin
            sum = {1'b0, level} + {1'b0, step};
            if (sum > {1'b0, max_level})
                sum = {1'b0, max_level};
        end else begin
            sum = {1'b0, level} - {1'b0, step};
            if (sum[SAT_W])
                sum = '0;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED channel. Holds the brightness level, steps it
// toward on/off on each update strobe, and registers the PWM drive bit.
//   clk_pll, rstn : clock, async active-low reset
//   clear         : synchronous clear of level and output (block disabled)
//   update        : apply one rise/fall step to the level this edge
//   bypass        : drive pwm_out straight from led_bit
//   led_bit       : sampled on/off request for this LED
//   rise_step, fall_step : step sizes
//   pwm_cnt       : shared PWM phase counter
//   pwm_out       : registered PWM drive
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk_pll,
    input  logic                rstn,
    input  logic                clear,
    input  logic                update,
    input  logic                bypass,
    input  logic                led_bit,
    input  logic [PWM_BITS-1:0] rise_step,
    input  logic [PWM_BITS-1:0] fall_step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] MAX_LVL = '1;

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_nxt;
    logic [PWM_BITS-1:0] step;

    assign step      = led_bit ? rise_step : fall_step;
    assign level_nxt = PWM_BITS'(sat_step(SAT_W'(level), SAT_W'(step), SAT_W'(MAX_LVL), led_bit));

    // update only fires on the last cycle of a frame, so a new level is first
    // compared against pwm_cnt=0 and never truncates a pulse in flight.
    always_ff @(posedge clk_pll or negedge rstn) begin
        if (!rstn)
            level <= '0;
        else if (clear)
            level <= '0;
        else if (update)
            level <= level_nxt;
    end

    // Full level forces a constant 1; otherwise L high cycles from pwm_cnt=0.
    always_ff @(posedge clk_pll or negedge rstn) begin
        if (!rstn)
            pwm_out <= 1'b0;
        else if (clear)
            pwm_out <= 1'b0;
        else if (bypass)
            pwm_out <= led_bit;
        else
            pwm_out <= (level == MAX_LVL) | (level > pwm_cnt);
    end

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: PWM output stage with per-LED fade-in/fade-out.
//   clk_pll     : system clock
//   rstn        : asynchronous active-low reset
//   led_in      : on/off pattern from the pattern generator
//   enable      : 0 = synchronously clear counters/levels, outputs 0
//   bypass      : 1 = pwm_out follows led_in (two-cycle latency)
//   rise_step   : level increment per update for lit LEDs
//   fall_step   : level decrement per update for dark LEDs
//   pwm_out     : PWM LED drive
//   update_tick : strobe, levels take their next step on the coming edge
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int NUM_LEDS    = DEF_NUM_LEDS,
    parameter int PWM_BITS    = DEF_PWM_BITS,
    parameter int STEP_FRAMES = DEF_STEP_FRAMES
) (
    input  logic                clk_pll,
    input  logic                rstn,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic                enable,
    input  logic                bypass,
    input  logic [PWM_BITS-1:0] rise_step,
    input  logic [PWM_BITS-1:0] fall_step,
    output logic [NUM_LEDS-1:0] pwm_out,
    output logic                update_tick
);

    localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;
    localparam logic [FW-1:0]       FRAME_MAX = FW'(STEP_FRAMES - 1);

    logic [NUM_LEDS-1:0] led_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FW-1:0]       frame_cnt;
    logic                frame_tick;

    // led_q is the only view of led_in the datapath uses; it is not cleared by
    // enable so bypass resumes cleanly.
    always_ff @(posedge clk_pll or negedge rstn) begin
        if (!rstn)
            led_q <= '0;
        else
            led_q <= led_in;
    end

    // Counters read as 0 while disabled, so update_tick is already 0 there;
    // the enable term keeps it low in the cycle enable drops.
    assign frame_tick  = (pwm_cnt == CNT_MAX);
    assign update_tick = enable && frame_tick && (frame_cnt == FRAME_MAX);

    always_ff @(posedge clk_pll or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt   <= '0;
            frame_cnt <= '0;
        end else if (!enable) begin
            pwm_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (frame_tick)
                frame_cnt <= (frame_cnt == FRAME_MAX) ? '0 : frame_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk_pll   (clk_pll),
            .rstn      (rstn),
            .clear     (!enable),
            .update    (update_tick),
            .bypass    (bypass),
            .led_bit   (led_q[i]),
            .rise_step (rise_step),
            .fall_step (fall_step),
            .pwm_cnt   (pwm_cnt),
            .pwm_out   (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;

    logic       clk_pll = 1'b0;
    logic       rstn;
    logic [7:0] led_in;
    logic       enable;
    logic       bypass;
    logic [3:0] rise_step;
    logic [3:0] fall_step;
    logic [7:0] pwm_out;
    logic       update_tick;

    int checks = 0;
    int errors = 0;

    led_fade_pwm dut (
        .clk_pll     (clk_pll),
        .rstn        (rstn),
        .led_in      (led_in),
        .enable      (enable),
        .bypass      (bypass),
        .rise_step   (rise_step),
        .fall_step   (fall_step),
        .pwm_out     (pwm_out),
        .update_tick (update_tick)
    );

    always #5 clk_pll = ~clk_pll;

    typedef struct {
        logic [7:0]      led;
        logic [3:0]      rise;
        logic [3:0]      fall;
        int              nupd;
        logic [7:0][4:0] duty;   // expected high cycles per 16, per LED (16 = constant on)
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Leaves the bench at the negedge where update_tick is high.
    task automatic wait_update(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_pll);
            if (update_tick === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, " update_tick timeout"}, 0, 1);
    endtask

    // Called at an update negedge: skip the old-level cycle, then count 16.
    task automatic measure(output int cnt[8]);
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        @(negedge clk_pll);
        @(negedge clk_pll);
        for (int c = 0; c < 16; c++) begin
            for (int b = 0; b < 8; b++) if (pwm_out[b] === 1'b1) cnt[b]++;
            @(negedge clk_pll);
        end
    endtask

    // From a counter-zero negedge (index 0), return the index of the first update_tick.
    task automatic first_tick_idx(output int idx, output bit out_zero);
        idx = -1;
        out_zero = 1;
        for (int k = 0; k < 200; k++) begin
            if (pwm_out !== 8'h00) out_zero = 0;
            if (update_tick === 1'b1) begin
                idx = k;
                break;
            end
            @(negedge clk_pll);
        end
    endtask

    initial begin
        int cnt[8];
        int idx;
        int ticks[$];
        bit zero;

        vecs[0]  = '{8'h00, 4'd0,  4'd0,  1,  {8{5'd0}}};
        vecs[1]  = '{8'hFF, 4'd15, 4'd0,  1,  {8{5'd16}}};
        vecs[2]  = '{8'h00, 4'd0,  4'd6,  1,  {8{5'd9}}};
        vecs[3]  = '{8'h00, 4'd0,  4'd6,  1,  {8{5'd3}}};
        vecs[4]  = '{8'h00, 4'd0,  4'd6,  1,  {8{5'd0}}};
        vecs[5]  = '{8'h00, 4'd0,  4'd6,  1,  {8{5'd0}}};
        vecs[6]  = '{8'h01, 4'd1,  4'd0,  4,  {{7{5'd0}}, 5'd4}};
        vecs[7]  = '{8'h01, 4'd1,  4'd0,  10, {{7{5'd0}}, 5'd14}};
        vecs[8]  = '{8'h01, 4'd5,  4'd0,  1,  {{7{5'd0}}, 5'd16}};
        vecs[9]  = '{8'h01, 4'd1,  4'd0,  1,  {{7{5'd0}}, 5'd16}};
        vecs[10] = '{8'h81, 4'd3,  4'd2,  1,  {5'd3, {6{5'd0}}, 5'd16}};
        vecs[11] = '{8'h80, 4'd3,  4'd0,  1,  {5'd6, {6{5'd0}}, 5'd16}};
        vecs[12] = '{8'h00, 4'd0,  4'd15, 1,  {8{5'd0}}};

        rstn = 1'b0; led_in = '0; enable = 1'b1; bypass = 1'b0;
        rise_step = '0; fall_step = '0;
        repeat (3) @(negedge clk_pll);
        chk("reset pwm_out", int'(pwm_out), 0);
        chk("reset update_tick", int'(update_tick), 0);

        // Tick timing from reset release; output stays dark throughout.
        rstn = 1'b1;
        zero = 1;
        for (int k = 0; k < 200; k++) begin
            if (update_tick === 1'b1) ticks.push_back(k);
            if (pwm_out !== 8'h00) zero = 0;
            @(negedge clk_pll);
        end
        chk("tick count", ticks.size(), 3);
        if (ticks.size() == 3) begin
            chk("tick0 cycle", ticks[0], 63);
            chk("tick1 cycle", ticks[1], 127);
            chk("tick2 cycle", ticks[2], 191);
        end
        chk("dark output", int'(zero), 1);

        // Table: inputs set mid-interval, then n updates, then one frame measured.
        for (int v = 0; v < 13; v++) begin
            led_in = vecs[v].led; rise_step = vecs[v].rise; fall_step = vecs[v].fall;
            for (int n = 0; n < vecs[v].nupd; n++) wait_update($sformatf("vec%0d", v));
            measure(cnt);
            for (int b = 0; b < 8; b++)
                chk($sformatf("vec%0d led%0d duty", v, b), cnt[b], int'(vecs[v].duty[b]));
        end

        // Bypass: two-cycle latency, levels keep tracking behind it.
        @(negedge clk_pll);
        bypass = 1'b1; led_in = 8'hA5; rise_step = 4'd15; fall_step = 4'd15;
        @(negedge clk_pll);
        chk("bypass 1 cycle", int'(pwm_out), 8'h00);
        @(negedge clk_pll);
        chk("bypass 2 cycles", int'(pwm_out), 8'hA5);
        wait_update("bypass");
        @(negedge clk_pll);
        led_in = 8'h5A;
        @(negedge clk_pll);
        @(negedge clk_pll);
        chk("bypass follows", int'(pwm_out), 8'h5A);
        bypass = 1'b0;
        @(negedge clk_pll);
        chk("bypass release level", int'(pwm_out), 8'hA5);

        // Enable drop clears everything; re-enable restarts like reset.
        enable = 1'b0;
        @(negedge clk_pll);
        chk("disable pwm_out", int'(pwm_out), 0);
        led_in = 8'h00; fall_step = 4'd0;
        zero = 1;
        for (int k = 0; k < 70; k++) begin
            if (update_tick !== 1'b0 || pwm_out !== 8'h00) zero = 0;
            @(negedge clk_pll);
        end
        chk("disabled idle", int'(zero), 1);
        enable = 1'b1;
        first_tick_idx(idx, zero);
        chk("reenable first tick", idx, 63);
        chk("reenable levels cleared", int'(zero), 1);

        // Async reset landing on an update cycle must suppress that update.
        led_in = 8'hFF; rise_step = 4'd15;
        wait_update("pre-reset");
        #1 rstn = 1'b0;
        #1;
        chk("async reset pwm_out", int'(pwm_out), 0);
        chk("async reset tick", int'(update_tick), 0);
        @(negedge clk_pll);
        rstn = 1'b1;
        first_tick_idx(idx, zero);
        chk("post-reset first tick", idx, 63);
        chk("post-reset no update", int'(zero), 1);
        measure(cnt);
        chk("post-reset update led0", cnt[0], 16);
        chk("post-reset update led7", cnt[7], 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
